// File: rtl/mlp_seq_ctrl.sv
// rtl/mlp_seq_ctrl.sv - sequential 9-3-1 MLP evaluator on one shared multiplier
// Optional MLP_SEQ_CLASS_EN adds registered class bit cls = (out != 0).
module mlp_seq_ctrl #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 22,
  parameter int OUT_W = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9*IN_W-1:0] inp,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid,
`ifdef MLP_SEQ_CLASS_EN
  output logic              cls,
`endif
  input  logic              out_ready
);

  typedef enum logic [1:0] {IDLE, L0, L1, DONE} state_t;

  localparam logic signed [7:0] W0 [27] = '{
    -8'sd30, -8'sd13,  8'sd3,  -8'sd8,   8'sd7,  8'sd7,  8'sd40, 8'sd10,  8'sd38,
     8'sd33,  8'sd68,  8'sd79,  8'sd58, -8'sd17,  8'sd40, 8'sd42, 8'sd6,  -8'sd20,
     8'sd50,  8'sd27, -8'sd7,  -8'sd13,  8'sd30,  8'sd74, 8'sd1, -8'sd20,  8'sd12};
  localparam logic signed [7:0] W1 [3] = '{-8'sd18, 8'sd86, 8'sd61};
  localparam logic signed [ACC_W-1:0] B0 [3] = '{22'sd662, -22'sd362, -22'sd441};
  localparam logic signed [ACC_W-1:0] B1 = -22'sd110178;

  state_t                   state;
  logic [9*IN_W-1:0]        feat_q;
  logic [1:0]               n;
  logic [3:0]               i;
  logic signed [ACC_W-1:0]  acc;
  logic [2:0][12:0]         hid;

  logic [4:0]               w_idx;
  logic [12:0]              opnd;
  logic signed [7:0]        wgt;
  logic signed [ACC_W-1:0]  base, prod, sum;

  assign in_ready = (state == IDLE);

  // One multiplier: operand is a zero-extended feature in L0, a hidden value in L1.
  always_comb begin
    w_idx = 5'(n) * 5'd9 + 5'(i);
    opnd  = '0;
    wgt   = '0;
    base  = acc;
    if (state == L1) begin
      case (i[1:0])
        2'd0:    opnd = hid[0];
        2'd1:    opnd = hid[1];
        default: opnd = hid[2];
      endcase
      wgt = (i[1:0] == 2'd0) ? W1[0] : (i[1:0] == 2'd1) ? W1[1] : W1[2];
      if (i == 4'd0) base = B1;
    end else begin
      opnd = {{(13-IN_W){1'b0}}, feat_q[IN_W*i +: IN_W]};
      wgt  = (w_idx < 5'd27) ? W0[w_idx] : 8'sd0;
      if (i == 4'd0) base = (n == 2'd0) ? B0[0] : (n == 2'd1) ? B0[1] : B0[2];
    end
    prod = $signed({{(ACC_W-13){1'b0}}, opnd}) * $signed({{(ACC_W-8){wgt[7]}}, wgt});
    sum  = base + prod;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      feat_q    <= '0;
      n         <= '0;
      i         <= '0;
      acc       <= '0;
      hid       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
`ifdef MLP_SEQ_CLASS_EN
      cls       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            feat_q <= inp;
            n      <= '0;
            i      <= '0;
            state  <= L0;
          end
        end
        L0: begin
          acc <= sum;
          if (i == 4'd8) begin
            hid[n] <= sum[ACC_W-1] ? 13'd0 : sum[12:0];
            i      <= '0;
            if (n == 2'd2) begin
              n     <= '0;
              state <= L1;
            end else begin
              n <= n + 2'd1;
            end
          end else begin
            i <= i + 4'd1;
          end
        end
        L1: begin
          acc <= sum;
          if (i == 4'd2) begin
            out       <= sum[ACC_W-1] ? '0 : sum[OUT_W-1:0];
            out_valid <= 1'b1;
`ifdef MLP_SEQ_CLASS_EN
            cls       <= !sum[ACC_W-1] && (sum[OUT_W-1:0] != '0);
`endif
            i         <= '0;
            state     <= DONE;
          end else begin
            i <= i + 4'd1;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
